// File: rtl/gf8_mul_arbiter.sv
// gf8_mul_arbiter
//   Two requesters share a single GF(2^8) multiplier. Round-robin arbitration
//   feeds a 2-stage pipeline:
//     S1 holds the 15-bit carryless product, its requester id and a valid bit.
//     S2 is the output register, holding the reduced 8-bit product, id and valid.
//   Ports:
//     clk, rst                 clock and synchronous active-high reset
//     reqN_valid/_a/_b/_ready  operand-pair handshake for requester N (N = 0, 1)
//     out_valid/_ready         result handshake
//     out_id                   requester that owns out_prod
//     out_prod                 a*b mod (x^8 + POLY)
//     busy                     high while either pipeline stage holds an entry
//   Parameter:
//     POLY                     low 8 bits of the reduction polynomial (x^8 implied)
module gf8_mul_arbiter #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_id,
    output logic [7:0] out_prod,
    output logic       busy
);

    logic        s1_valid;
    logic        s1_id;
    logic [14:0] s1_prod;
    logic        last_grant;

    logic        adv_out;
    logic        adv_s1;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [14:0] clmul;
    logic [14:0] red;
    logic [7:0]  red_prod;

    assign adv_out = !out_valid | out_ready;
    assign adv_s1  = !s1_valid | adv_out;

    // Under contention, the pointer names the previous winner and the other
    // requester is granted.
    assign grant0 = req0_valid & (!req1_valid | last_grant);
    assign grant1 = req1_valid & (!req0_valid | !last_grant);

    assign req0_ready = grant0 & adv_s1 & !rst;
    assign req1_ready = grant1 & adv_s1 & !rst;
    assign accept     = (grant0 | grant1) & adv_s1;

    assign op_a = grant1 ? req1_a : req0_a;
    assign op_b = grant1 ? req1_b : req0_b;

    always_comb begin
        clmul = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            for (int unsigned j = 0; j < 8; j++) begin
                clmul[i+j] = clmul[i+j] ^ (op_a[i] & op_b[j]);
            end
        end
    end

    // Fold the high bits from the top down. Each fold can set lower bits that
    // are still above bit 7, so the descending order matters.
    always_comb begin
        red = s1_prod;
        for (int unsigned k = 14; k >= 8; k--) begin
            if (red[k]) begin
                red[k-8 +: 8] = red[k-8 +: 8] ^ POLY;
                red[k]        = 1'b0;
            end
        end
        red_prod = red[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_id      <= 1'b0;
            s1_prod    <= '0;
            out_valid  <= 1'b0;
            out_id     <= 1'b0;
            out_prod   <= '0;
            last_grant <= 1'b1;
        end else begin
            if (adv_s1) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_prod    <= clmul;
                    s1_id      <= grant1;
                    last_grant <= grant1;
                end
            end
            if (adv_out) begin
                out_valid <= s1_valid;
                out_id    <= s1_id;
                out_prod  <= red_prod;
            end
        end
    end

    assign busy = s1_valid | out_valid;

endmodule

// File: tb/tb_gf8_mul_arbiter.sv
// tb_gf8_mul_arbiter
//   Directed bench for gf8_mul_arbiter: reset state, single products,
//   back-to-back issue, round-robin under contention, output stall, reset
//   flush, then a random stream checked against a shift-and-add GF(2^8)
//   model with one ordered queue per requester.
module tb_gf8_mul_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       req1_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_id;
    logic [7:0] out_prod;
    logic       busy;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    gf8_mul_arbiter #(.POLY(8'h1B)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_prod   (out_prod),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Shift-and-add multiply with x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    initial begin
        logic [7:0] va[5];
        logic [7:0] vb[5];
        logic [7:0] vp[5];
        va = '{8'h00, 8'h01, 8'hC3, 8'hFF, 8'h03};
        vb = '{8'hA5, 8'hA5, 8'h01, 8'h00, 8'h03};
        vp = '{8'h00, 8'hA5, 8'hC3, 8'h00, 8'h05};

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
        out_ready = 1'b1;

        // Readies stay low while rst is high, even with both requesters valid
        @(negedge clk); rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; #1;
        chk1("rst_ready0", req0_ready, 1'b0);
        chk1("rst_ready1", req1_ready, 1'b0);
        @(negedge clk); rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; #1;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_out_id", out_id, 1'b0);
        chk8("reset_out_prod", out_prod, 8'h00);
        chk1("reset_busy", busy, 1'b0);

        // 57*83 = C1, two edges after acceptance
        @(negedge clk); req0_valid = 1'b1; req0_a = 8'h57; req0_b = 8'h83; #1;
        chk1("p1_ready0", req0_ready, 1'b1);
        @(negedge clk); req0_valid = 1'b0; #1;
        chk1("p1_lat1_valid", out_valid, 1'b0);
        chk1("p1_lat1_busy", busy, 1'b1);
        @(negedge clk); req1_valid = 1'b1; req1_a = 8'h02; req1_b = 8'h80; #1;
        chk1("p1_valid", out_valid, 1'b1);
        chk1("p1_id", out_id, 1'b0);
        chk8("p1_prod", out_prod, 8'hC1);
        chk1("p2_ready1", req1_ready, 1'b1);

        // Requester 1 back to back: 02*80 = 1B, 53*CA = 01
        @(negedge clk); req1_a = 8'h53; req1_b = 8'hCA; #1;
        chk1("p3_ready1", req1_ready, 1'b1);
        chk1("p3_gap_valid", out_valid, 1'b0);
        @(negedge clk); req1_valid = 1'b0; #1;
        chk1("p2_valid", out_valid, 1'b1);
        chk1("p2_id", out_id, 1'b1);
        chk8("p2_prod", out_prod, 8'h1B);
        @(negedge clk); #1;
        chk1("p3_valid", out_valid, 1'b1);
        chk1("p3_id", out_id, 1'b1);
        chk8("p3_prod", out_prod, 8'h01);
        @(negedge clk); #1;
        chk1("p3_drained", out_valid, 1'b0);
        chk1("p3_idle", busy, 1'b0);

        // Zero and one operands, streamed at full rate
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            if (n < 5) begin
                req0_valid = 1'b1; req0_a = va[n]; req0_b = vb[n];
            end else begin
                req0_valid = 1'b0;
            end
            #1;
            if (n < 5) chk1("id_ready0", req0_ready, 1'b1);
            if (n >= 2) begin
                chk1("id_valid", out_valid, 1'b1);
                chk1("id_id", out_id, 1'b0);
                chk8("id_prod", out_prod, vp[n-2]);
            end
        end

        // Contention straight out of reset: grants 0,1,0,1
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req0_a = 8'h02; req0_b = 8'h03;
        req1_a = 8'h05; req1_b = 8'h01;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req0_valid = (k < 4);
            req1_valid = (k < 4);
            #1;
            if (k < 4) begin
                chk1("rr_ready0", req0_ready, (k % 2) == 0);
                chk1("rr_ready1", req1_ready, (k % 2) == 1);
            end
            if (k >= 2) begin
                chk1("rr_valid", out_valid, 1'b1);
                chk1("rr_id", out_id, ((k - 2) % 2) == 1);
                chk8("rr_prod", out_prod, ((k - 2) % 2) == 1 ? 8'h05 : 8'h06);
            end
        end

        // Output stall with both requesters valid
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req0_a = 8'h57; req0_b = 8'h83;
        req1_a = 8'h02; req1_b = 8'h80;
        @(negedge clk); req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1; #1;
        chk1("st1_ready0", req0_ready, 1'b1);
        chk1("st1_ready1", req1_ready, 1'b0);
        @(negedge clk); out_ready = 1'b0; #1;
        chk1("st2_ready0", req0_ready, 1'b0);
        chk1("st2_ready1", req1_ready, 1'b1);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); out_ready = 1'b0; #1;
            chk1("st_hold_ready0", req0_ready, 1'b0);
            chk1("st_hold_ready1", req1_ready, 1'b0);
            chk1("st_hold_valid", out_valid, 1'b1);
            chk1("st_hold_id", out_id, 1'b0);
            chk8("st_hold_prod", out_prod, 8'hC1);
        end
        @(negedge clk); out_ready = 1'b1; #1;
        chk1("st5_ready0", req0_ready, 1'b1);
        chk1("st5_ready1", req1_ready, 1'b0);
        chk8("st5_prod", out_prod, 8'hC1);
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; #1;
        chk1("st6_id", out_id, 1'b1);
        chk8("st6_prod", out_prod, 8'h1B);
        @(negedge clk); #1;
        chk1("st7_valid", out_valid, 1'b1);
        chk1("st7_id", out_id, 1'b0);
        chk8("st7_prod", out_prod, 8'hC1);
        @(negedge clk); #1;
        chk1("st8_valid", out_valid, 1'b0);
        chk1("st8_busy", busy, 1'b0);

        // Reset one cycle after an acceptance flushes the entry
        @(negedge clk); req0_valid = 1'b1; req0_a = 8'h57; req0_b = 8'h83; #1;
        chk1("rf_ready0", req0_ready, 1'b1);
        @(negedge clk); rst = 1'b1; #1;
        chk1("rf_rst_ready0", req0_ready, 1'b0);
        chk1("rf_rst_valid", out_valid, 1'b0);
        @(negedge clk); rst = 1'b0; req0_valid = 1'b0; #1;
        chk1("rf_post_valid", out_valid, 1'b0);
        chk1("rf_post_busy", busy, 1'b0);
        @(negedge clk); #1;
        chk1("rf_post2_valid", out_valid, 1'b0);

        // Random traffic against the reference model
        for (int i = 0; i < 3010; i++) begin
            @(negedge clk);
            req0_valid = (i < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
            req1_valid = (i < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            out_ready = (i < 3000) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            chk1("rnd_one_grant", req0_ready & req1_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (out_id == 1'b0) begin
                    chk1("rnd_q0_nonempty", q0.size() != 0, 1'b1);
                    if (q0.size() != 0) chk8("rnd_prod0", out_prod, q0.pop_front());
                end else begin
                    chk1("rnd_q1_nonempty", q1.size() != 0, 1'b1);
                    if (q1.size() != 0) chk8("rnd_prod1", out_prod, q1.pop_front());
                end
            end
            if (req0_valid && req0_ready) q0.push_back(gmul(req0_a, req0_b));
            if (req1_valid && req1_ready) q1.push_back(gmul(req1_a, req1_b));
        end
        chk1("rnd_q0_drained", q0.size() == 0, 1'b1);
        chk1("rnd_q1_drained", q1.size() == 0, 1'b1);
        chk1("rnd_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
